peak_rate_meter: RTL and testbench

- Consumes the FIR-filtered sample stream (10-bit, one strobe per sample) and detects peaks using hysteresis and a refractory window.
- Measures the interval between accepted peaks in samples and averages the last 4 intervals.
- Converts the average to a rate in events per minute with an iterative divider.
- Sits directly downstream of the filter stage and replaces the bare peak/trough counting with a usable rate output.

---
 rtl/peak_rate_meter_if.sv | 24 ++
 rtl/peak_rate_meter.sv | 252 +++++++++++++++++++++++++
 tb/tb_peak_rate_meter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/peak_rate_meter_if.sv
// Sample-stream and rate-result signals of the peak/rate meter.
// The sample source is the master; the meter is the slave.
interface peak_rate_meter_if #(
    parameter int DW = 10,
    parameter int CW = 9
);
    logic          sample_valid;
    logic [DW-1:0] sample;
    logic          peak_pulse;
    logic [CW-1:0] interval;
    logic [8:0]    rate;
    logic          rate_valid;
    logic          locked;

    modport master (
        output sample_valid, sample,
        input  peak_pulse, interval, rate, rate_valid, locked
    );

    modport slave (
        input  sample_valid, sample,
        output peak_pulse, interval, rate, rate_valid, locked
    );
endinterface

// File: rtl/peak_rate_meter.sv
// Hysteresis peak detector with refractory window, 4-interval history and an
// iterative divider that turns the interval sum into events per minute.
module peak_rate_meter #(
    parameter int DW      = 10,
    parameter int FS      = 100,
    parameter int HYST    = 8,
    parameter int MIN_INT = 20,
    parameter int MAX_INT = 400
) (
    input  logic             clk,
    input  logic             reset,
    peak_rate_meter_if.slave bus
);
    localparam int            CW     = $clog2(MAX_INT + 1);
    localparam int            SW     = 12;
    localparam int            NW     = 15;
    localparam logic [NW-1:0] NUM    = NW'(60 * FS * 4);
    localparam logic [DW:0]   HYST_X = (DW + 1)'(HYST);
    localparam logic [CW:0]   MIN_X  = (CW + 1)'(MIN_INT);
    localparam logic [CW:0]   MAX_X  = (CW + 1)'(MAX_INT);
    localparam logic [CW-1:0] MAX_CW = CW'(MAX_INT);

    typedef enum logic [1:0] {
        DET_UNPRIMED = 2'd0,
        DET_RISING   = 2'd1,
        DET_FALLING  = 2'd2
    } det_state_t;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_LOAD = 2'd1,
        DIV_ITER = 2'd2
    } div_state_t;

    det_state_t    det_state_r, det_state_s;
    logic [DW-1:0] ext_r, ext_s;
    logic [DW:0]   sample_x_s, ext_x_s;
    logic          cand_s, accept_s, push_s, timeout_s, start_div_s;
    logic [CW:0]   cnt_inc_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic          armed_r, armed_s;
    // Only three past intervals are kept: the incoming one completes the window.
    logic [CW-1:0] hist_r [0:2];
    logic [CW-1:0] hist_s [0:2];
    logic [2:0]    hcount_r, hcount_s;
    logic [CW-1:0] interval_r, interval_s;
    logic          locked_r, locked_s;
    logic          peak_pulse_r, peak_pulse_s;
    logic [SW-1:0] sum_s;

    div_state_t    div_state_r, div_state_s;
    logic [SW-1:0] divisor_r, divisor_s;
    logic [SW-1:0] rem_r, rem_s;
    logic [NW-1:0] quo_r, quo_s;
    logic [SW:0]   trial_s;
    logic [3:0]    iter_r, iter_s;
    logic [8:0]    rate_r, rate_s;
    logic          rate_valid_r, rate_valid_s;

    // Detector next state: extremum tracking with hysteresis, widened to avoid wrap.
    always_comb begin
        sample_x_s  = {1'b0, bus.sample};
        ext_x_s     = {1'b0, ext_r};
        det_state_s = det_state_r;
        ext_s       = ext_r;
        cand_s      = 1'b0;
        if (bus.sample_valid) begin
            case (det_state_r)
                DET_UNPRIMED: begin
                    ext_s       = bus.sample;
                    det_state_s = DET_RISING;
                end
                DET_RISING: begin
                    if (sample_x_s > ext_x_s) begin
                        ext_s = bus.sample;
                    end else if (sample_x_s + HYST_X <= ext_x_s) begin
                        cand_s      = 1'b1;
                        ext_s       = bus.sample;
                        det_state_s = DET_FALLING;
                    end else begin
                        ext_s = ext_r;
                    end
                end
                DET_FALLING: begin
                    if (sample_x_s < ext_x_s) begin
                        ext_s = bus.sample;
                    end else if (sample_x_s >= ext_x_s + HYST_X) begin
                        ext_s       = bus.sample;
                        det_state_s = DET_RISING;
                    end else begin
                        ext_s = ext_r;
                    end
                end
                default: det_state_s = DET_UNPRIMED;
            endcase
        end else begin
            det_state_s = det_state_r;
        end
    end

    // Interval counting, refractory acceptance, history and timeout.
    always_comb begin
        cnt_inc_s    = {1'b0, cnt_r} + {{CW{1'b0}}, 1'b1};
        accept_s     = cand_s && ((cnt_inc_s >= MIN_X) || !armed_r);
        push_s       = accept_s && armed_r;
        timeout_s    = bus.sample_valid && !accept_s && (cnt_inc_s >= MAX_X);
        sum_s        = SW'(cnt_inc_s) + SW'(hist_r[0]) + SW'(hist_r[1]) + SW'(hist_r[2]);
        cnt_s        = cnt_r;
        armed_s      = armed_r;
        hist_s[0]    = hist_r[0];
        hist_s[1]    = hist_r[1];
        hist_s[2]    = hist_r[2];
        hcount_s     = hcount_r;
        interval_s   = interval_r;
        locked_s     = locked_r;
        peak_pulse_s = accept_s;
        start_div_s  = 1'b0;
        if (accept_s) begin
            cnt_s   = {CW{1'b0}};
            armed_s = 1'b1;
            if (push_s) begin
                interval_s = cnt_inc_s[CW-1:0];
                hist_s[0]  = cnt_inc_s[CW-1:0];
                hist_s[1]  = hist_r[0];
                hist_s[2]  = hist_r[1];
                hcount_s   = (hcount_r == 3'd4) ? 3'd4 : (hcount_r + 3'd1);
                if (hcount_s == 3'd4) begin
                    locked_s    = 1'b1;
                    start_div_s = 1'b1;
                end else begin
                    locked_s = locked_r;
                end
            end else begin
                interval_s = interval_r;
            end
        end else if (timeout_s) begin
            cnt_s     = MAX_CW;
            armed_s   = 1'b0;
            hist_s[0] = {CW{1'b0}};
            hist_s[1] = {CW{1'b0}};
            hist_s[2] = {CW{1'b0}};
            hcount_s  = 3'd0;
            locked_s  = 1'b0;
        end else if (bus.sample_valid) begin
            cnt_s = cnt_inc_s[CW-1:0];
        end else begin
            cnt_s = cnt_r;
        end
    end

    // Restoring divider: NUM / sum, one load cycle then one quotient bit per clk.
    always_comb begin
        div_state_s  = div_state_r;
        divisor_s    = divisor_r;
        rem_s        = rem_r;
        quo_s        = quo_r;
        iter_s       = iter_r;
        rate_s       = rate_r;
        rate_valid_s = 1'b0;
        trial_s      = {rem_r, quo_r[NW-1]};
        if (timeout_s) begin
            div_state_s = DIV_IDLE;
            rate_s      = 9'd0;
        end else if (start_div_s) begin
            div_state_s = DIV_LOAD;
            divisor_s   = sum_s;
        end else begin
            case (div_state_r)
                DIV_IDLE: div_state_s = DIV_IDLE;
                DIV_LOAD: begin
                    rem_s       = {SW{1'b0}};
                    quo_s       = NUM;
                    iter_s      = 4'd0;
                    div_state_s = DIV_ITER;
                end
                DIV_ITER: begin
                    if (trial_s >= {1'b0, divisor_r}) begin
                        rem_s = SW'(trial_s - {1'b0, divisor_r});
                        quo_s = {quo_r[NW-2:0], 1'b1};
                    end else begin
                        rem_s = trial_s[SW-1:0];
                        quo_s = {quo_r[NW-2:0], 1'b0};
                    end
                    if (iter_r == 4'(NW - 1)) begin
                        rate_s       = quo_s[8:0];
                        rate_valid_s = 1'b1;
                        div_state_s  = DIV_IDLE;
                    end else begin
                        iter_s = iter_r + 4'd1;
                    end
                end
                default: div_state_s = DIV_IDLE;
            endcase
        end
    end

    // Detector, counter and history registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            det_state_r  <= DET_UNPRIMED;
            ext_r        <= {DW{1'b0}};
            cnt_r        <= {CW{1'b0}};
            armed_r      <= 1'b0;
            hist_r[0]    <= {CW{1'b0}};
            hist_r[1]    <= {CW{1'b0}};
            hist_r[2]    <= {CW{1'b0}};
            hcount_r     <= 3'd0;
            interval_r   <= {CW{1'b0}};
            locked_r     <= 1'b0;
            peak_pulse_r <= 1'b0;
        end else begin
            det_state_r  <= det_state_s;
            ext_r        <= ext_s;
            cnt_r        <= cnt_s;
            armed_r      <= armed_s;
            hist_r[0]    <= hist_s[0];
            hist_r[1]    <= hist_s[1];
            hist_r[2]    <= hist_s[2];
            hcount_r     <= hcount_s;
            interval_r   <= interval_s;
            locked_r     <= locked_s;
            peak_pulse_r <= peak_pulse_s;
        end
    end

    // Divider and rate output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_state_r  <= DIV_IDLE;
            divisor_r    <= {SW{1'b0}};
            rem_r        <= {SW{1'b0}};
            quo_r        <= {NW{1'b0}};
            iter_r       <= 4'd0;
            rate_r       <= 9'd0;
            rate_valid_r <= 1'b0;
        end else begin
            div_state_r  <= div_state_s;
            divisor_r    <= divisor_s;
            rem_r        <= rem_s;
            quo_r        <= quo_s;
            iter_r       <= iter_s;
            rate_r       <= rate_s;
            rate_valid_r <= rate_valid_s;
        end
    end

    assign bus.peak_pulse = peak_pulse_r;
    assign bus.interval   = interval_r;
    assign bus.rate       = rate_r;
    assign bus.rate_valid = rate_valid_r;
    assign bus.locked     = locked_r;
endmodule

// File: tb/tb_peak_rate_meter.sv
// Randomized bench for peak_rate_meter against a sample-index based reference model.
module tb_peak_rate_meter;
    localparam int DW      = 10;
    localparam int CW      = 9;
    localparam int HYST    = 8;
    localparam int MIN_INT = 20;
    localparam int MAX_INT = 400;
    localparam int NUM     = 24000;
    localparam int GAP     = 20;

    logic clk = 1'b0;
    logic reset;

    peak_rate_meter_if #(.DW(DW), .CW(CW)) bus ();

    peak_rate_meter #(
        .DW(DW), .FS(100), .HYST(HYST), .MIN_INT(MIN_INT), .MAX_INT(MAX_INT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: peaks located by sample index, intervals as index gaps.
    int m_idx, m_last, m_ext, m_dir, m_interval, m_rate;
    bit m_primed, m_armed, m_locked;
    int m_hist[$];
    bit e_peak, e_rupd;

    function automatic void model_reset();
        m_idx = 0; m_last = -1; m_ext = 0; m_dir = 1; m_interval = 0; m_rate = 0;
        m_primed = 0; m_armed = 0; m_locked = 0;
        m_hist.delete();
        e_peak = 0; e_rupd = 0;
    endfunction

    function automatic void model_step(input int v);
        bit cand;
        int gap, sum;
        cand = 0;
        gap  = m_idx - m_last;
        if (!m_primed) begin
            m_primed = 1; m_ext = v; m_dir = 1;
        end else if (m_dir == 1) begin
            if (v > m_ext) m_ext = v;
            else if (v + HYST <= m_ext) begin cand = 1; m_ext = v; m_dir = -1; end
        end else begin
            if (v < m_ext) m_ext = v;
            else if (v >= m_ext + HYST) begin m_ext = v; m_dir = 1; end
        end
        e_peak = 0;
        e_rupd = 0;
        if (cand && (gap >= MIN_INT || !m_armed)) begin
            e_peak = 1;
            if (m_armed) begin
                m_interval = gap;
                m_hist.push_back(gap);
                if (m_hist.size() > 4) void'(m_hist.pop_front());
                if (m_hist.size() == 4) begin
                    sum = 0;
                    foreach (m_hist[k]) sum += m_hist[k];
                    m_locked = 1;
                    m_rate   = NUM / sum;
                    e_rupd   = 1;
                end
            end
            m_armed = 1;
            m_last  = m_idx;
        end else if (gap >= MAX_INT) begin
            m_armed = 0; m_locked = 0; m_rate = 0;
            m_hist.delete();
        end
        m_idx++;
    endfunction

    function automatic int tri_val(input int ph, input int period);
        int half;
        half = period / 2;
        return (ph <= half) ? (ph * 400 / half) : ((period - ph) * 400 / half);
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_peak"}, bus.peak_pulse, 0);
        check_val({tag, "_interval"}, bus.interval, 0);
        check_val({tag, "_rate"}, bus.rate, 0);
        check_val({tag, "_rate_valid"}, bus.rate_valid, 0);
        check_val({tag, "_locked"}, bus.locked, 0);
    endtask

    // One strobe, then watch the gap; optionally reset mid-division.
    task automatic send_sample(input int v, input bit reset_on_div, output bit did_reset);
        int rv_seen, rv_rate, stray;
        did_reset = 0;
        @(negedge clk);
        bus.sample       = DW'(v);
        bus.sample_valid = 1'b1;
        @(negedge clk);
        bus.sample_valid = 1'b0;
        model_step(v);
        check_val("peak_pulse", bus.peak_pulse, e_peak);
        check_val("interval", bus.interval, m_interval);
        check_val("locked", bus.locked, m_locked);
        rv_seen = 0; rv_rate = 0; stray = 0;
        for (int i = 1; i < GAP; i++) begin
            @(negedge clk);
            if (did_reset && reset == 1'b0) reset = 1'b1;
            if (reset_on_div && e_rupd && i == 6) begin
                #2 reset = 1'b0;
                #1 check_reset_outputs("async_reset");
                model_reset();
                did_reset = 1;
            end
            if (bus.rate_valid) begin rv_seen++; rv_rate = bus.rate; end
            if (bus.peak_pulse) stray++;
        end
        check_val("rate_valid_count", rv_seen, e_rupd);
        if (e_rupd) check_val("rate_value", rv_rate, m_rate);
        check_val("rate_hold", bus.rate, m_rate);
        check_val("stray_peak", stray, 0);
    endtask

    task automatic send_tri(input int period, input int nper, input int ripple);
        bit d;
        int v;
        for (int p = 0; p < nper; p++) begin
            for (int ph = 0; ph < period; ph++) begin
                v = tri_val(ph, period);
                if (ripple > 0) v = v + int'($urandom_range(2 * ripple, 0)) - ripple;
                if (v < 0) v = 0;
                if (v > 1023) v = 1023;
                send_sample(v, 1'b0, d);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit d;
        int guard, k, lvl;
        int refr[] = '{0, 80, 160, 240, 320, 400, 300, 250, 200, 150,
                       200, 240, 280, 320, 360, 420, 300, 200, 100, 0};
        reset = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        reset = 1'b1;

        send_tri(50, 6, 0);
        check_val("p50_rate", bus.rate, 120);
        check_val("p50_interval", bus.interval, 50);
        check_val("p50_locked", bus.locked, 1);

        send_tri(50, 6, 5);
        check_val("ripple_rate", bus.rate, 120);

        send_tri(40, 5, 0);
        check_val("p40_rate", bus.rate, 150);
        check_val("p40_interval", bus.interval, 40);

        foreach (refr[j]) send_sample(refr[j], 1'b0, d);
        send_tri(50, 5, 0);

        for (int r = 0; r < 5; r++) send_tri(30 + 2 * int'($urandom_range(25, 0)), 1, 3);
        for (int r = 0; r < 100; r++) send_sample(int'($urandom_range(1023, 0)), 1'b0, d);
        send_tri(50, 4, 2);

        lvl = int'($urandom_range(20, 0));
        for (int r = 0; r < 450; r++) send_sample(lvl, 1'b0, d);
        check_val("timeout_locked", bus.locked, 0);
        check_val("timeout_rate", bus.rate, 0);

        send_tri(50, 6, 0);
        check_val("relock_rate", bus.rate, 120);
        check_val("relock_locked", bus.locked, 1);

        d = 0; guard = 0; k = 0;
        while (!d && guard < 300) begin
            send_sample(tri_val(k % 50, 50), 1'b1, d);
            k++;
            guard++;
        end
        check_val("reset_triggered", d, 1);

        send_tri(50, 3, 0);
        check_val("post_reset_unlocked", bus.locked, 0);
        send_tri(50, 3, 0);
        check_val("post_reset_rate", bus.rate, 120);
        check_val("post_reset_locked", bus.locked, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
